// File: rtl/tt_um_accelshark_psg_i2s_rx.sv
// ---------------------------------------------------------------------------
// tt_um_accelshark_psg_i2s_rx
//
// I2S receiver for the PSG audio link (far end of the PSG I2S transmitter).
// SCLK, LRCK and SDATA are oversampled on the system clock. MSB-first stereo
// slots are deserialised, and one left/right pair is presented per frame.
// The pair is qualified by a single-cycle valid strobe.
//
// Parameters
//   SAMPLE_W  sample bits captured per slot (MSB first); extra slot bits ignored
//   SYNC_ST   synchroniser depth on sclk/lrck/sdata (>= 2)
//
// Ports
//   clk        system clock, at least 8x the SCLK frequency
//   rst_n      asynchronous active-low reset
//   ena        design enable; low holds samples and drops the receiver to HUNT
//   sclk       I2S bit clock (asynchronous to clk)
//   lrck       I2S word select: 0 = left, 1 = right
//   sdata      I2S serial data
//   sample_l   last complete left sample
//   sample_r   last complete right sample
//   valid      one-cycle pulse; sample_l/sample_r updated in this cycle
//   frame_err  sticky short-slot flag
//
// Build option
//   PSG_I2S_RX_ERR_EN  when defined, a short slot seen outside HUNT sets
//                      frame_err (cleared by rst_n or ena low). When it is
//                      undefined, frame_err is tied low. Recovery from a short
//                      slot is the same in both builds.
// ---------------------------------------------------------------------------
module tt_um_accelshark_psg_i2s_rx #(
  parameter int SAMPLE_W = 8,
  parameter int SYNC_ST  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                sclk,
  input  logic                lrck,
  input  logic                sdata,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                valid,
  output logic                frame_err
);

  localparam int               CNT_W    = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_W - 1);

  typedef enum logic [2:0] {
    HUNT,
    L_SHIFT,
    L_PAD,
    R_SHIFT,
    R_PAD
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronisers and edge history. All three inputs see the same delay, so
  // lrck/sdata taken in the event cycle are the values present at the SCLK
  // rising edge on the pins.
  // -------------------------------------------------------------------------
  logic [SYNC_ST-1:0] sclk_sync;
  logic [SYNC_ST-1:0] lrck_sync;
  logic [SYNC_ST-1:0] sdata_sync;
  logic               sclk_d;
  logic               lrck_prev;

  logic sclk_s;
  logic lrck_s;
  logic data_s;
  logic bit_evt;
  logic slot_start;

  assign sclk_s     = sclk_sync[SYNC_ST-1];
  assign lrck_s     = lrck_sync[SYNC_ST-1];
  assign data_s     = sdata_sync[SYNC_ST-1];
  assign bit_evt    = sclk_s & ~sclk_d;
  assign slot_start = bit_evt & (lrck_s != lrck_prev);

  // The synchronisers and lrck history run regardless of ena. After ena
  // returns high, a genuine left slot start is then detected on the first
  // real lrck 1->0 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments only. Every flop
    // then samples pre-edge values, and the simulation matches the netlist.
    if (!rst_n) begin
      sclk_sync  <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      sclk_d     <= 1'b0;
      lrck_prev  <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_ST-2:0], sclk};
      lrck_sync  <= {lrck_sync[SYNC_ST-2:0], lrck};
      sdata_sync <= {sdata_sync[SYNC_ST-2:0], sdata};
      sclk_d     <= sclk_s;
      if (bit_evt) lrck_prev <= lrck_s;
    end
  end

  // -------------------------------------------------------------------------
  // Slot FSM and deserialiser
  // -------------------------------------------------------------------------
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] shifted;
  logic [SAMPLE_W-1:0] pend_l;
  logic                out_pend;   // right word complete, publish next cycle

  always_comb begin
    // NOTE: every always_comb output gets a value on every path. This
    // prevents the tool from inferring a latch.
    cnt_next = cnt;
    if (cnt != CNT_MAX) cnt_next = cnt + CNT_W'(1);
  end

  assign shifted = {shreg[SAMPLE_W-2:0], data_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      cnt      <= '0;
      shreg    <= '0;
      pend_l   <= '0;
      out_pend <= 1'b0;
      sample_l <= '0;
      sample_r <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!ena) begin
        state    <= HUNT;
        cnt      <= '0;
        out_pend <= 1'b0;
      end else begin
        // Both samples are updated together so that a pair always comes from one frame.
        if (out_pend) begin
          sample_l <= pend_l;
          sample_r <= shreg;
          valid    <= 1'b1;
          out_pend <= 1'b0;
        end

        if (slot_start) begin
          // Delay slot of I2S: no data is shifted, and the bit count restarts.
          cnt   <= '0;
          shreg <= '0;
          unique case (state)
            HUNT:    if (!lrck_s) state <= L_SHIFT;
            L_PAD:   if (lrck_s)  state <= R_SHIFT;
            R_PAD:   if (!lrck_s) state <= L_SHIFT;
            // Short slot: drop the pair, but still honour the new edge.
            L_SHIFT,
            R_SHIFT: state <= lrck_s ? HUNT : L_SHIFT;
            default: state <= HUNT;
          endcase
        end else if (bit_evt) begin
          cnt <= cnt_next;
          if (state == L_SHIFT || state == R_SHIFT) begin
            shreg <= shifted;
            if (cnt == CNT_LAST) begin
              if (state == L_SHIFT) begin
                pend_l <= shifted;
                state  <= L_PAD;
              end else begin
                out_pend <= 1'b1;
                state    <= R_PAD;
              end
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional sticky short-slot flag
  // -------------------------------------------------------------------------
`ifdef PSG_I2S_RX_ERR_EN
  logic short_slot;

  assign short_slot = ena & slot_start & ((state == L_SHIFT) | (state == R_SHIFT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          frame_err <= 1'b0;
    else if (!ena)       frame_err <= 1'b0;
    else if (short_slot) frame_err <= 1'b1;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_accelshark_psg_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_tt_um_accelshark_psg_i2s_rx
//
// Directed bench for the PSG I2S receiver. The bench plays the transmitter.
// SCLK is clk/8, and data and LRCK change with the falling SCLK edge. Every
// slot opens with the I2S delay bit, which is followed by MSB-first data.
// ---------------------------------------------------------------------------
module tb_tt_um_accelshark_psg_i2s_rx;

  localparam int SAMPLE_W = 8;
  localparam int SYNC_ST  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                ena = 1'b1;
  logic                sclk = 1'b0;
  logic                lrck = 1'b0;
  logic                sdata = 1'b0;
  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic                valid;
  logic                frame_err;

  tt_um_accelshark_psg_i2s_rx #(
    .SAMPLE_W(SAMPLE_W),
    .SYNC_ST (SYNC_ST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .sclk     (sclk),
    .lrck     (lrck),
    .sdata    (sdata),
    .sample_l (sample_l),
    .sample_r (sample_r),
    .valid    (valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcount = 0;
  int last_valid_cyc = 0;
  int last_rise_cyc = 0;

`ifdef PSG_I2S_RX_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Count the cycles in which valid is high. A stuck strobe inflates the count.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount         <= vcount + 1;
      last_valid_cyc <= cyc;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic lr, input logic d);
    sclk  = 1'b0;
    lrck  = lr;
    sdata = d;
    repeat (4) @(negedge clk);
    sclk          = 1'b1;
    last_rise_cyc = cyc;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic lr, input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(lr, w[i]);
  endtask

  // Delay bit (deliberately 1, because it must never be shifted in) plus n data bits.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int n);
    send_bit(lr, 1'b1);
    send_bits(lr, w, n);
  endtask

  task automatic frame(input logic [7:0] l, input logic [7:0] r);
    send_slot(1'b0, {8'h00, l}, 8);
    send_slot(1'b1, {8'h00, r}, 8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    sclk  = 1'b0;
    lrck  = 1'b0;
    sdata = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_pair(input string name, input int base, input int exp_cnt,
                            input logic [7:0] exp_l, input logic [7:0] exp_r);
    checks++;
    if ((vcount - base) !== exp_cnt) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, vcount - base, exp_cnt);
    end
    checks++;
    if (sample_l !== exp_l) begin
      failures++;
      $display("FAIL %s_l got=%h exp=%h", name, sample_l, exp_l);
    end
    checks++;
    if (sample_r !== exp_r) begin
      failures++;
      $display("FAIL %s_r got=%h exp=%h", name, sample_r, exp_r);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    do_reset();
    checks++;
    if (sample_l !== 8'h00) begin
      failures++; $display("FAIL reset_l got=%h exp=00", sample_l);
    end
    checks++;
    if (sample_r !== 8'h00) begin
      failures++; $display("FAIL reset_r got=%h exp=00", sample_r);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", valid);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=0", frame_err);
    end
  endtask

  task automatic test_frames();
    int base;
    base = vcount;
    send_slot(1'b1, 16'h0000, 8);              // lead-in right slot, ignored in HUNT
    send_slot(1'b0, 16'h00A5, 8);
    idle(8);
    check_pair("frm_pre", base, 0, 8'h00, 8'h00);
    send_slot(1'b1, 16'h003C, 8);
    idle(8);
    check_pair("frm1", base, 1, 8'hA5, 8'h3C);
    frame(8'hA5, 8'h3C);
    idle(8);
    check_pair("frm2", base, 2, 8'hA5, 8'h3C);
    frame(8'h0F, 8'hF0);                       // back-to-back, different data
    idle(8);
    check_pair("frm3", base, 3, 8'h0F, 8'hF0);
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL frm_err got=%b exp=0", frame_err);
    end
  endtask

  task automatic test_mid_start();
    int base;
    do_reset();
    base = vcount;
    send_bits(1'b1, 16'h000F, 4);              // tail end of a right slot
    send_slot(1'b0, 16'h00C3, 8);
    idle(8);
    check_pair("mid_pre", base, 0, 8'h00, 8'h00);
    send_slot(1'b1, 16'h005A, 8);
    idle(8);
    check_pair("mid", base, 1, 8'hC3, 8'h5A);
    checks++;
    if ((last_valid_cyc - last_rise_cyc) !== SYNC_ST + 2) begin
      failures++;
      $display("FAIL latency got=%0d exp=%0d", last_valid_cyc - last_rise_cyc, SYNC_ST + 2);
    end
  endtask

  task automatic test_wide_slots();
    int base;
    do_reset();
    base = vcount;
    send_slot(1'b1, 16'h0000, 16);
    send_slot(1'b0, 16'h81FF, 16);
    send_slot(1'b1, 16'h7E00, 16);
    idle(8);
    check_pair("wide", base, 1, 8'h81, 8'h7E);
  endtask

  task automatic test_short_slot();
    int base;
    do_reset();
    base = vcount;
    send_slot(1'b1, 16'h0000, 8);
    send_slot(1'b0, 16'h0005, 4);              // 5-bit left slot
    send_slot(1'b1, 16'h0099, 8);              // dropped: receiver is in HUNT
    idle(8);
    check_pair("short_pre", base, 0, 8'h00, 8'h00);
    checks++;
    if (frame_err !== EXP_ERR) begin
      failures++; $display("FAIL short_err got=%b exp=%b", frame_err, EXP_ERR);
    end
    frame(8'h11, 8'h22);
    idle(8);
    check_pair("short_rec", base, 1, 8'h11, 8'h22);
    checks++;
    if (frame_err !== EXP_ERR) begin
      failures++; $display("FAIL short_err_sticky got=%b exp=%b", frame_err, EXP_ERR);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    do_reset();
    base = vcount;
    send_slot(1'b1, 16'h0000, 8);
    frame(8'h55, 8'hAA);
    idle(8);
    check_pair("rstm_pre", base, 1, 8'h55, 8'hAA);
    send_slot(1'b0, 16'h0012, 8);
    send_slot(1'b1, 16'h0005, 3);              // partway through R_SHIFT
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample_l !== 8'h00 || sample_r !== 8'h00 || valid !== 1'b0) begin
      failures++;
      $display("FAIL rstm_async got=%h/%h/%b exp=00/00/0", sample_l, sample_r, valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base  = vcount;
    send_bits(1'b1, 16'h0015, 5);
    frame(8'h66, 8'h99);
    idle(8);
    check_pair("rstm_post", base, 1, 8'h66, 8'h99);
  endtask

  task automatic test_ena_hold();
    int base;
    do_reset();
    send_slot(1'b1, 16'h0000, 8);
    frame(8'h55, 8'hAA);
    idle(8);
    base = vcount;
    ena = 1'b0;
    frame(8'h01, 8'h02);
    frame(8'h03, 8'h04);
    frame(8'h05, 8'h06);
    idle(8);
    check_pair("ena_low", base, 0, 8'h55, 8'hAA);
    send_slot(1'b0, 16'h0007, 3);              // left slot already under way
    ena = 1'b1;
    send_bits(1'b0, 16'h001F, 5);
    send_slot(1'b1, 16'h0077, 8);
    idle(8);
    check_pair("ena_nolock", base, 0, 8'h55, 8'hAA);
    frame(8'h21, 8'h43);
    idle(8);
    check_pair("ena_relock", base, 1, 8'h21, 8'h43);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_mid_start();
    test_wide_slots();
    test_short_slot();
    test_reset_mid_frame();
    test_ena_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
